// File: rtl/fifo_ms_merge.sv
// Merges FLUX independent payload streams into one tagged stream: a private circular
// buffer per flux, round-robin selection and a registered single-word output.
module fifo_ms_merge #(
   parameter  int WIDTH      = 8,
   parameter  int DEPTH      = 4,
   parameter  int FLUX       = 2,
   localparam int TAG_WIDTH  = $clog2(FLUX),
   localparam int PAY_WIDTH  = WIDTH - TAG_WIDTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                      ck,
   input  logic                      rst,
   input  logic [FLUX-1:0]           wr,
   input  logic [FLUX*PAY_WIDTH-1:0] datain,
   input  logic [FLUX-1:0]           down_full,
   output logic [FLUX-1:0]           full,
   output logic [FLUX-1:0]           empty,
   output logic                      wr_out,
   output logic [WIDTH-1:0]          dataout
);

   logic [ADDR_WIDTH-1:0] wp_q [FLUX];
   logic [ADDR_WIDTH-1:0] wp_d [FLUX];
   logic [ADDR_WIDTH-1:0] rp_q [FLUX];
   logic [ADDR_WIDTH-1:0] rp_d [FLUX];
   logic [FLUX-1:0]       wnr_q, wnr_d;
   logic [PAY_WIDTH-1:0]  mem_q [FLUX][DEPTH];
   logic [TAG_WIDTH-1:0]  last_q, last_d;
   logic                  wr_out_q, wr_out_d;
   logic [WIDTH-1:0]      dataout_q, dataout_d;

   logic [FLUX-1:0]       full_c, empty_c, wr_acc, eligible, pop;
   logic                  grant_valid;
   logic [TAG_WIDTH-1:0]  grant_idx, arb_idx, out_tag;

   assign out_tag = dataout_q[WIDTH-1 -: TAG_WIDTH];

   // The word sitting in the output register is not yet visible in down_full,
   // so its flux is held off for one cycle.
   always_comb begin
      full_c   = '0;
      empty_c  = '0;
      wr_acc   = '0;
      eligible = '0;
      for (int i = 0; i < FLUX; i++) begin
         full_c[i]   = (wp_q[i] == rp_q[i]) &&  wnr_q[i];
         empty_c[i]  = (wp_q[i] == rp_q[i]) && !wnr_q[i];
         wr_acc[i]   = wr[i] && !full_c[i];
         eligible[i] = !empty_c[i] && !down_full[i] &&
                       !(wr_out_q && (out_tag == TAG_WIDTH'(i)));
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      arb_idx     = '0;
      for (int k = 1; k <= FLUX; k++) begin
         arb_idx = last_q + TAG_WIDTH'(k);
         if (!grant_valid && eligible[arb_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = arb_idx;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (grant_valid) pop[grant_idx] = 1'b1;
   end

   always_comb begin
      wp_d      = wp_q;
      rp_d      = rp_q;
      wnr_d     = wnr_q;
      last_d    = last_q;
      wr_out_d  = grant_valid;
      dataout_d = dataout_q;
      for (int i = 0; i < FLUX; i++) begin
         if (wr_acc[i]) wp_d[i] = wp_q[i] + ADDR_WIDTH'(1);
         if (pop[i])    rp_d[i] = rp_q[i] + ADDR_WIDTH'(1);
         if (wr_acc[i] && !pop[i])      wnr_d[i] = 1'b1;
         else if (pop[i] && !wr_acc[i]) wnr_d[i] = 1'b0;
      end
      if (grant_valid) begin
         last_d    = grant_idx;
         dataout_d = {grant_idx, mem_q[grant_idx][rp_q[grant_idx]]};
      end
   end

   always_ff @(posedge ck) begin
      if (!rst) begin
         for (int i = 0; i < FLUX; i++) begin
            wp_q[i] <= '0;
            rp_q[i] <= '0;
         end
         wnr_q     <= '0;
         last_q    <= TAG_WIDTH'(FLUX - 1);
         wr_out_q  <= 1'b0;
         dataout_q <= '0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         wnr_q     <= wnr_d;
         last_q    <= last_d;
         wr_out_q  <= wr_out_d;
         dataout_q <= dataout_d;
      end
   end

   // Storage is left unreset; pointers alone define what is valid.
   always_ff @(posedge ck) begin
      for (int i = 0; i < FLUX; i++) begin
         if (wr_acc[i]) mem_q[i][wp_q[i]] <= datain[i*PAY_WIDTH +: PAY_WIDTH];
      end
   end

   assign full    = full_c;
   assign empty   = empty_c;
   assign wr_out  = wr_out_q;
   assign dataout = dataout_q;

endmodule

// File: tb/tb_fifo_ms_merge.sv
// Bench for fifo_ms_merge (WIDTH=8, DEPTH=4, FLUX=2): cycle table plus hand sequences,
// with a per-flux scoreboard checking every emitted word.
module tb_fifo_ms_merge;

   logic       ck = 1'b0;
   logic       rst;
   logic [1:0] wr;
   logic [13:0] datain;
   logic [1:0] down_full;
   logic [1:0] full, empty;
   logic       wr_out;
   logic [7:0] dataout;

   int n_pass  = 0;
   int n_total = 0;
   bit mon_en  = 1'b0;

   logic [7:0] sbq0[$];
   logic [7:0] sbq1[$];
   logic [7:0] exp_w;

   fifo_ms_merge #(.WIDTH(8), .DEPTH(4), .FLUX(2)) dut (
      .ck(ck), .rst(rst), .wr(wr), .datain(datain), .down_full(down_full),
      .full(full), .empty(empty), .wr_out(wr_out), .dataout(dataout)
   );

   always #5 ck = ~ck;

   typedef struct {
      logic       rst;
      logic [1:0] wr;
      logic [6:0] d0;
      logic [6:0] d1;
      logic [1:0] dfull;
      logic [1:0] acc;
      logic [1:0] e_full;
      logic [1:0] e_empty;
      logic       e_wr_out;
      logic [7:0] e_dout;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
   endtask

   task automatic drive(input logic r, input logic [1:0] w, input logic [6:0] p0,
                        input logic [6:0] p1, input logic [1:0] df);
      rst       = r;
      wr        = w;
      datain    = {p1, p0};
      down_full = df;
   endtask

   task automatic push(input logic [1:0] w, input logic [6:0] p0, input logic [6:0] p1);
      if (w[0]) sbq0.push_back({1'b0, p0});
      if (w[1]) sbq1.push_back({1'b1, p1});
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // Every emitted word must be the oldest outstanding one of its flux.
   always @(negedge ck) begin
      if (mon_en && wr_out === 1'b1) begin
         if (dataout[7] == 1'b0 && sbq0.size() > 0) begin
            exp_w = sbq0.pop_front();
            chk("sb_flux0", {24'd0, dataout}, {24'd0, exp_w});
         end else if (dataout[7] == 1'b1 && sbq1.size() > 0) begin
            exp_w = sbq1.pop_front();
            chk("sb_flux1", {24'd0, dataout}, {24'd0, exp_w});
         end else begin
            n_total++;
            $display("FAIL sb_unexpected: got word %0h, expected no output", dataout);
         end
      end
   end

   initial begin
      int cnt;
      //         rst wr     d0     d1     dfull  acc    e_full e_empty wo    dout
      tbl[0]  = '{0, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00};
      tbl[1]  = '{1, 2'b01, 7'h15, 7'h00, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0, 8'h00};
      tbl[2]  = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 8'h15};
      tbl[3]  = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h15};
      tbl[4]  = '{1, 2'b10, 7'h00, 7'h15, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 8'h15};
      tbl[5]  = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 8'h95};
      tbl[6]  = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h95};
      tbl[7]  = '{1, 2'b10, 7'h00, 7'h01, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 8'h95};
      tbl[8]  = '{1, 2'b10, 7'h00, 7'h02, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 8'h95};
      tbl[9]  = '{1, 2'b10, 7'h00, 7'h03, 2'b10, 2'b10, 2'b00, 2'b01, 1'b0, 8'h95};
      tbl[10] = '{1, 2'b10, 7'h00, 7'h04, 2'b10, 2'b10, 2'b10, 2'b01, 1'b0, 8'h95};
      tbl[11] = '{1, 2'b10, 7'h00, 7'h05, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 8'h95};
      tbl[12] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 8'h81};
      tbl[13] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 8'h81};
      tbl[14] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 8'h82};
      tbl[15] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 8'h82};
      tbl[16] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 8'h83};
      tbl[17] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 8'h83};
      tbl[18] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 8'h84};
      tbl[19] = '{1, 2'b00, 7'h00, 7'h00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h84};

      drive(1'b0, 2'b00, 7'h00, 7'h00, 2'b00);
      @(negedge ck);

      // single words, latency, fill-to-full, dropped write, in-order drain
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].rst, tbl[i].wr, tbl[i].d0, tbl[i].d1, tbl[i].dfull);
         push(tbl[i].acc, tbl[i].d0, tbl[i].d1);
         tick();
         mon_en = 1'b1;
         chk($sformatf("row%0d full", i),    {30'd0, full},    {30'd0, tbl[i].e_full});
         chk($sformatf("row%0d empty", i),   {30'd0, empty},   {30'd0, tbl[i].e_empty});
         chk($sformatf("row%0d wr_out", i),  {31'd0, wr_out},  {31'd0, tbl[i].e_wr_out});
         chk($sformatf("row%0d dataout", i), {24'd0, dataout}, {24'd0, tbl[i].e_dout});
      end

      // both fluxes backlogged: alternate tags, one word every cycle
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 2'b11, 7'(8'h20 + k), 7'(8'h40 + k), 2'b11);
         push(2'b11, 7'(8'h20 + k), 7'(8'h40 + k));
         tick();
      end
      chk("alt_full_both", {30'd0, full}, 32'd3);
      drive(1'b1, 2'b00, 7'h00, 7'h00, 2'b00);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("alt%0d wr_out", k), {31'd0, wr_out}, 32'd1);
         chk($sformatf("alt%0d tag", k), {31'd0, dataout[7]}, k % 2);
      end
      tick();
      chk("alt_idle wr_out", {31'd0, wr_out}, 32'd0);
      chk("alt_idle empty", {30'd0, empty}, 32'd3);

      // single backlogged flux: held off while its word is in flight
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'b01, 7'(8'h60 + k), 7'h00, 2'b01);
         push(2'b01, 7'(8'h60 + k), 7'h00);
         tick();
      end
      drive(1'b1, 2'b00, 7'h00, 7'h00, 2'b00);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("solo%0d wr_out", k), {31'd0, wr_out}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick();
      chk("solo_end empty", {30'd0, empty}, 32'd3);

      // write and pop together keep occupancy; a write while full is dropped even with a pop
      drive(1'b1, 2'b10, 7'h00, 7'h31, 2'b10); push(2'b10, 7'h00, 7'h31); tick();
      drive(1'b1, 2'b10, 7'h00, 7'h32, 2'b10); push(2'b10, 7'h00, 7'h32); tick();
      chk("half empty", {30'd0, empty}, 32'd1);
      chk("half full", {30'd0, full}, 32'd0);
      drive(1'b1, 2'b10, 7'h00, 7'h33, 2'b00); push(2'b10, 7'h00, 7'h33); tick();
      chk("wrpop wr_out", {31'd0, wr_out}, 32'd1);
      chk("wrpop empty", {30'd0, empty}, 32'd1);
      chk("wrpop full", {30'd0, full}, 32'd0);
      drive(1'b1, 2'b10, 7'h00, 7'h34, 2'b10); push(2'b10, 7'h00, 7'h34); tick();
      chk("occ3 full", {30'd0, full}, 32'd0);
      drive(1'b1, 2'b10, 7'h00, 7'h35, 2'b10); push(2'b10, 7'h00, 7'h35); tick();
      chk("occ4 full", {30'd0, full}, 32'd2);
      drive(1'b1, 2'b10, 7'h00, 7'h36, 2'b00); tick();
      chk("nofall full", {30'd0, full}, 32'd0);
      drive(1'b1, 2'b00, 7'h00, 7'h00, 2'b00);
      for (int k = 0; k < 8; k++) tick();
      chk("wrpop_end empty", {30'd0, empty}, 32'd3);

      // reset with words buffered and a grant pending
      drive(1'b1, 2'b11, 7'h0A, 7'h0B, 2'b11); tick();
      drive(1'b1, 2'b01, 7'h0C, 7'h00, 2'b11); tick();
      chk("pre_rst empty", {30'd0, empty}, 32'd0);
      drive(1'b0, 2'b00, 7'h00, 7'h00, 2'b00); tick();
      chk("rst empty", {30'd0, empty}, 32'd3);
      chk("rst full", {30'd0, full}, 32'd0);
      chk("rst wr_out", {31'd0, wr_out}, 32'd0);
      chk("rst dataout", {24'd0, dataout}, 32'd0);
      drive(1'b1, 2'b00, 7'h00, 7'h00, 2'b00);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (wr_out === 1'b1) cnt++;
      end
      chk("post_rst words", cnt, 32'd0);

      chk("sb0 drained", sbq0.size(), 32'd0);
      chk("sb1 drained", sbq1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
